// File: rtl/jk_exc_pkg.sv
`default_nettype none
// ============================================================================
// jk_exc_pkg
//   Shared types and the JK excitation function for jk_exc_seq.
//   Build option: JK_EXC_TOGGLE_EN selects toggle (J=K=T^Q) don't-care fill.
//   Revision: 1.0
// ============================================================================
package jk_exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Returns {J, K} that moves one JK flip-flop from q to t.
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
`ifdef JK_EXC_TOGGLE_EN
        return {q ^ t, q ^ t};
`else
        return {~q & t, q & ~t};
`endif
    endfunction

endpackage : jk_exc_pkg
`default_nettype wire

// File: rtl/jk_exc_fifo.sv
`default_nettype none
// ============================================================================
// jk_exc_fifo
//   Synchronous target FIFO with full/empty flags and an occupancy counter.
//   Revision: 1.0
// ============================================================================
module jk_exc_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule : jk_exc_fifo
`default_nettype wire

// File: rtl/jk_exc_seq.sv
`default_nettype none
// ============================================================================
// jk_exc_seq
//   Excitation sequencer for a JK flip-flop bank: queues target words, drives
//   J/K to reach each target, strobes the bank and checks the returned Q.
//   Build option: JK_EXC_TOGGLE_EN (toggle encoding; default set/reset).
//   Revision: 1.0
// ============================================================================
module jk_exc_seq
    import jk_exc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             apply,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] q_model,
    output logic             busy,
    output logic             err
);

    state_t           r_state;
    state_t           w_next_state;

    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;
    logic             w_pop;

    logic [WIDTH-1:0] w_j_d;
    logic [WIDTH-1:0] w_k_d;
    logic [1:0]       w_jk_bit;

    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_apply;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_q_model;
    logic             r_err;

    jk_exc_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tgt_valid),
        .push_data (tgt_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = w_empty ? ST_IDLE : ST_APPLY;
            ST_APPLY: w_next_state = ST_CHECK;
            ST_CHECK: w_next_state = w_empty ? ST_IDLE : ST_APPLY;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Excitation is computed from the model while the next target is popped,
    // so it is already registered on the bank inputs during APPLY.
    always_comb begin
        w_pop    = 1'b0;
        w_j_d    = '0;
        w_k_d    = '0;
        w_jk_bit = 2'b00;
        if ((r_state == ST_IDLE || r_state == ST_CHECK) && !w_empty) begin
            w_pop = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                w_jk_bit = jk_excite(r_q_model[i], w_head[i]);
                w_j_d[i] = w_jk_bit[1];
                w_k_d[i] = w_jk_bit[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_j       <= '0;
            r_k       <= '0;
            r_apply   <= 1'b0;
            r_tgt     <= '0;
            r_q_model <= '0;
            r_err     <= 1'b0;
        end else begin
            r_j     <= w_j_d;
            r_k     <= w_k_d;
            r_apply <= w_pop;
            if (w_pop) begin
                r_tgt <= w_head;
            end
            if (r_state == ST_APPLY) begin
                r_q_model <= r_tgt;
            end
            if (r_state == ST_CHECK && q_fb != r_q_model) begin
                r_err <= 1'b1;
            end
        end
    end

    assign j_out     = r_j;
    assign k_out     = r_k;
    assign apply     = r_apply;
    assign q_model   = r_q_model;
    assign err       = r_err;
    assign tgt_ready = !w_full;
    assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule : jk_exc_seq
`default_nettype wire

// File: tb/tb_jk_exc_seq.sv
`default_nettype none
// ============================================================================
// tb_jk_exc_seq
//   Self-checking bench for jk_exc_seq with a looped-back behavioural JK bank.
//   Revision: 1.0
// ============================================================================
module tb_jk_exc_seq;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             apply;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] q_model;
    logic             busy;
    logic             err;

    logic [WIDTH-1:0] bank_q;
    logic             force_en;

    always #5 clk = ~clk;

    jk_exc_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .j_out     (j_out),
        .k_out     (k_out),
        .apply     (apply),
        .q_fb      (q_fb),
        .q_model   (q_model),
        .busy      (busy),
        .err       (err)
    );

    // Behavioural jk_ff bank, clock-enabled by apply.
    always @(posedge clk) begin
        if (rst) bank_q <= '0;
        else if (apply) bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
    end
    assign q_fb = force_en ? 4'b0000 : bank_q;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] j;
        logic [3:0] k;
    } vec_t;

    vec_t       sb[$];
    vec_t       vec[6];
    logic [3:0] bw[8];
    logic [3:0] m_q;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       pend = 1'b0;
    logic [3:0] pend_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_jk(input logic [3:0] q, input logic [3:0] t);
`ifdef JK_EXC_TOGGLE_EN
        return {q ^ t, q ^ t};
`else
        return {~q & t, q & ~t};
`endif
    endfunction

    // Scoreboard consumer: each APPLY pops one expectation, the CHECK cycle
    // after it confirms the model and the bank feedback.
    always @(negedge clk) begin
        vec_t e;
        if (rst) begin
            pend = 1'b0;
        end else if (apply) begin
            if (sb.size() == 0) begin
                chk("apply_unexpected", 32'(apply), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("j_out", 32'(j_out), 32'(e.j));
                chk("k_out", 32'(k_out), 32'(e.k));
                pend   = 1'b1;
                pend_t = e.t;
            end
        end else if (pend) begin
            chk("q_model", 32'(q_model), 32'(pend_t));
            chk("check_jk_zero", 32'({j_out, k_out}), 32'd0);
            if (!force_en) chk("q_fb", 32'(q_fb), 32'(pend_t));
            pend = 1'b0;
        end
    end

    task automatic push_one(input logic [3:0] t, input logic [3:0] ej, input logic [3:0] ek);
        int cyc = 0;
        tgt_valid = 1'b1;
        tgt_data  = t;
        while (!tgt_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("push_ready", 32'(tgt_ready), 32'd1);
        sb.push_back('{t: t, j: ej, k: ek});
        m_q = t;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
    endtask

    task automatic push_model(input logic [3:0] t);
        logic [7:0] jk;
        jk = model_jk(m_q, t);
        push_one(t, jk[7:4], jk[3:0]);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    // Holds tgt_valid for n words and tracks FIFO occupancy from pushes and
    // APPLY strobes (each APPLY means a pop on the preceding edge).
    task automatic burst(input int n, output logic saw_full);
        int   idx = 0;
        int   occ = 0;
        int   cyc = 0;
        logic took;
        logic [7:0] jk;
        saw_full  = 1'b0;
        tgt_valid = 1'b1;
        tgt_data  = bw[0];
        while (idx < n && cyc < 100) begin
            took = tgt_ready;
            if (took) begin
                jk = model_jk(m_q, bw[idx]);
                sb.push_back('{t: bw[idx], j: jk[7:4], k: jk[3:0]});
                m_q = bw[idx];
            end
            @(posedge clk); #1;
            cyc++;
            occ = occ + int'(took) - int'(apply);
            chk("tgt_ready_vs_occupancy", 32'(tgt_ready), 32'(occ < DEPTH));
            if (!tgt_ready) saw_full = 1'b1;
            if (took) begin
                idx++;
                if (idx < n) tgt_data = bw[idx];
            end
        end
        tgt_valid = 1'b0;
        chk("burst_all_pushed", 32'(idx), 32'(n));
    endtask

    initial begin
        logic saw_full;
        logic saw_apply;

`ifdef JK_EXC_TOGGLE_EN
        vec[0] = '{t: 4'b1010, j: 4'b1010, k: 4'b1010};
        vec[1] = '{t: 4'b0110, j: 4'b1100, k: 4'b1100};
        vec[2] = '{t: 4'b1111, j: 4'b1001, k: 4'b1001};
        vec[3] = '{t: 4'b0000, j: 4'b1111, k: 4'b1111};
        vec[4] = '{t: 4'b0101, j: 4'b0101, k: 4'b0101};
        vec[5] = '{t: 4'b0011, j: 4'b0110, k: 4'b0110};
`else
        vec[0] = '{t: 4'b1010, j: 4'b1010, k: 4'b0000};
        vec[1] = '{t: 4'b0110, j: 4'b0100, k: 4'b1000};
        vec[2] = '{t: 4'b1111, j: 4'b1001, k: 4'b0000};
        vec[3] = '{t: 4'b0000, j: 4'b0000, k: 4'b1111};
        vec[4] = '{t: 4'b0101, j: 4'b0101, k: 4'b0000};
        vec[5] = '{t: 4'b0011, j: 4'b0010, k: 4'b0100};
`endif
        bw = '{4'h3, 4'hC, 4'h5, 4'h5, 4'hF, 4'h0, 4'h9, 4'h6};

        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        force_en  = 1'b0;
        m_q       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tgt_ready", 32'(tgt_ready), 32'd1);
        chk("rst_jk", 32'({j_out, k_out}), 32'd0);
        chk("rst_apply", 32'(apply), 32'd0);
        chk("rst_q_model", 32'(q_model), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            push_one(vec[i].t, vec[i].j, vec[i].k);
            wait_idle();
            chk("table_q_model", 32'(q_model), 32'(vec[i].t));
        end
        chk("table_err", 32'(err), 32'd0);

        burst(8, saw_full);
        chk("burst_saw_full", 32'(saw_full), 32'd1);
        wait_idle();
        chk("burst_q_model", 32'(q_model), 32'(bw[7]));
        chk("burst_sb_drained", 32'(sb.size()), 32'd0);
        chk("burst_err", 32'(err), 32'd0);

        // Corrupted feedback during the CHECK of target 1111.
        push_model(4'b1111);
        for (int c = 0; c < 20 && !apply; c++) begin
            @(posedge clk); #1;
        end
        chk("err_test_apply_seen", 32'(apply), 32'd1);
        @(posedge clk); #1;
        force_en = 1'b1;
        chk("err_before_edge", 32'(err), 32'd0);
        @(posedge clk); #1;
        force_en = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        push_model(4'b0101);
        wait_idle();
        push_model(4'b1100);
        wait_idle();
        chk("err_sticky", 32'(err), 32'd1);

        // Reset while APPLY is active and the FIFO still holds entries.
        burst(6, saw_full);
        chk("rst_mid_apply_active", 32'(apply), 32'd1);
        chk("rst_mid_fifo_nonempty", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        m_q = '0;
        chk("rst_mid_apply", 32'(apply), 32'd0);
        chk("rst_mid_jk", 32'({j_out, k_out}), 32'd0);
        chk("rst_mid_q_model", 32'(q_model), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_ready", 32'(tgt_ready), 32'd1);
        rst = 1'b0;
        saw_apply = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (apply || busy) saw_apply = 1'b1;
        end
        chk("rst_mid_flushed", 32'(saw_apply), 32'd0);

        push_model(4'b1010);
        wait_idle();
        chk("post_rst_q_model", 32'(q_model), 32'hA);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_jk_exc_seq
`default_nettype wire
